zpu_sd_bridge: RTL and testbench
================================

Name: zpu_sd_bridge

Overview:
- Bridges the ZPU disk-firmware register interface to the hps_io virtual-disk sector interface.
- Holds a 512-byte sector buffer that is dual-ported between the ZPU side and the HPS side.
- Latches the sector LBA and issues per-drive block read/write requests with a request/ack state machine.
- Publishes mount events (file number, file type, read-only flag, size) to the ZPU. Sits between hps_io (SD side) and atari800top (ZPU_IN2/IN3, ZPU_OUT2/OUT3, ZPU_RD/WR).

Parameters:
- SECT_AW, 9, sector buffer address width (512 bytes).
- NDRV, 3, number of hps_io virtual disk slots.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- zpu_out2  in  32  control: [0] lba_sel, [1] block_rd, [2] block_wr, [5:3] drv_num
- zpu_out3  in  32  write data (LBA or byte in [7:0])
- zpu_wr  in  16  write strobes: [5] io_wr (pointer clear), [6] data_wr
- zpu_rd  in  16  read strobes: [2] data_rd
- zpu_in2  out  8  status: [0] io_done, [1] mounted toggle, [4:2] fileno, [6:5] filetype, [7] readonly
- zpu_in3  out  32  lba_sel ? filesize : {24'b0, buffer byte at pointer}
- sd_lba  out  32  sector address to hps_io
- sd_rd  out  NDRV  per-slot read request
- sd_wr  out  NDRV  per-slot write request
- sd_ack  in  1  hps_io transfer acknowledge
- sd_buff_addr  in  SECT_AW  HPS-side buffer address
- sd_buff_dout  in  8  HPS-side write data
- sd_buff_din  out  8  HPS-side read data
- sd_buff_wr  in  1  HPS-side write enable
- img_mounted  in  NDRV  mount pulse per slot
- img_readonly  in  1  read-only flag of the mounted image
- img_size  in  64  image size in bytes
- img_filetype  in  2  file type (ioctl_index[7:6])

Behaviour:
- Reset (async, active-high): every register and output cleared to 0. This covers sd_lba, sd_rd, sd_wr, the pointer, io_done, mounted, fileno, filetype, readonly, filesize and FSM=IDLE. Buffer RAM contents are not cleared.
- Data write path:
  - zpu_wr[6] passes through a 2-flop delay. The rising edge of the delayed copy is the write event, seen 2 cycles after the strobe rises.
  - If lba_sel=1, sd_lba <= zpu_out3.
  - Otherwise byte zpu_out3[7:0] is written at the pointer, and the pointer increments on the following cycle.
- Data read path:
  - zpu_in3 presents the buffer byte at the pointer with 1-cycle RAM latency.
  - The pointer increments on the falling edge of zpu_rd[2].
- Pointer:
  - SECT_AW bits wide; wraps 511 -> 0.
  - zpu_wr[5] high forces it to 0, with priority over any same-cycle increment.
- Drive slot map: slot = {drv_num[2], drv_num[0]}, so 0->0, 1->1, 4->2. Any other drv_num is invalid.
- FSM states IDLE, REQ, XFER:
  - IDLE:
    - A rising edge of block_rd or block_wr with a valid slot asserts sd_rd[slot] or sd_wr[slot], clears io_done and goes to REQ.
    - If both edges arrive in the same cycle, read wins and the write is dropped.
    - An invalid slot asserts no request and sets io_done the next cycle.
  - REQ: hold the request until sd_ack=1, then clear all sd_rd/sd_wr and go to XFER.
  - XFER: on sd_ack falling, set io_done and go to IDLE.
  - block_rd/block_wr edges arriving in REQ or XFER are ignored.
- Mount:
  - Trigger is the rising edge of |img_mounted.
  - fileno: slot0->0, slot1->1, slot2->4; the highest slot wins if several pulse together.
  - filetype <= img_filetype; readonly <= img_readonly | img_mounted[2].
  - filesize <= img_size[31:0], truncated.
  - mounted toggles.
  - reset drives mounted to 0.
- HPS side: a true dual-port buffer. A same-address collision between ZPU and HPS writes is undefined; firmware never does this.

Decomposition:
- Shared package holds:
  - ZPU control bit-index constants (LBA_SEL, BLK_RD, BLK_WR, DRV_LSB/MSB, IO_WR, DATA_WR, DATA_RD).
  - The fileno codes 0, 1, 4.
  - The state enum {IDLE, REQ, XFER}.
- One sub-module: the existing dpram, 9x8, used as the sector buffer.

Test Plan:
- Pulse io_wr, write bytes 0xA5 then 0x5A, pulse io_wr, read twice -> zpu_in3 reads 0xA5 then 0x5A.
- lba_sel=1, write 0x00001234 -> sd_lba=0x1234; then block_rd with drv 4 -> sd_rd=3'b100, io_done=0. sd_ack high 3 cycles -> sd_rd=0; sd_ack falls -> io_done=1 the next cycle.
- block_rd and block_wr rise together with drv 1 -> sd_rd=3'b010, sd_wr=0. A second block_rd during XFER -> no new request.
- drv_num=2 block_wr -> sd_wr stays 0 and io_done=1 within 2 cycles.
- img_mounted=3'b100, img_size=0x1_0000_2000 -> fileno=4, readonly=1, filesize=0x2000, mounted toggled; lba_sel=1 -> zpu_in3=0x2000.
- 512 writes from pointer 0, then one more -> address 0 overwritten; assert reset during REQ -> sd_rd=0, FSM=IDLE, mounted=0.

Source files
------------

// File: rtl/zpu_sd_bridge_pkg.sv
// zpu_sd_bridge_pkg: shared ZPU register bit positions, fileno codes and FSM states
package zpu_sd_bridge_pkg;
  localparam int LBA_SEL = 0;
  localparam int BLK_RD = 1;
  localparam int BLK_WR = 2;
  localparam int DRV_LSB = 3;
  localparam int DRV_MSB = 5;
  localparam int IO_WR = 5;
  localparam int DATA_WR = 6;
  localparam int DATA_RD = 2;
  localparam logic [2:0] FILENO0 = 3'd0;
  localparam logic [2:0] FILENO1 = 3'd1;
  localparam logic [2:0] FILENO2 = 3'd4;
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
endpackage

// File: rtl/zpu_sd_bridge_dpram.sv
// zpu_sd_bridge_dpram: true dual-port sector buffer, registered reads on both ports
module zpu_sd_bridge_dpram #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  input  logic          wr_a,
  output logic [DW-1:0] dout_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] din_b,
  input  logic          wr_b,
  output logic [DW-1:0] dout_b
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (wr_a) mem[addr_a] <= din_a;
    if (wr_b) mem[addr_b] <= din_b;
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
  end
endmodule

// File: rtl/zpu_sd_bridge.sv
// zpu_sd_bridge: ZPU disk register interface to hps_io virtual-disk sector interface
module zpu_sd_bridge
  import zpu_sd_bridge_pkg::*;
#(
  parameter int SECT_AW = 9,
  parameter int NDRV = 3
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [31:0]        zpu_out2,
  input  logic [31:0]        zpu_out3,
  input  logic [15:0]        zpu_wr,
  input  logic [15:0]        zpu_rd,
  output logic [7:0]         zpu_in2,
  output logic [31:0]        zpu_in3,
  output logic [31:0]        sd_lba,
  output logic [NDRV-1:0]    sd_rd,
  output logic [NDRV-1:0]    sd_wr,
  input  logic               sd_ack,
  input  logic [SECT_AW-1:0] sd_buff_addr,
  input  logic [7:0]         sd_buff_dout,
  output logic [7:0]         sd_buff_din,
  input  logic               sd_buff_wr,
  input  logic [NDRV-1:0]    img_mounted,
  input  logic               img_readonly,
  input  logic [63:0]        img_size,
  input  logic [1:0]         img_filetype
);
  logic [2:0] dwr_q;
  logic [1:0] blk_q;
  logic rd_q, ack_q, mnt_q, inc_q;
  logic [SECT_AW-1:0] ptr;
  logic io_done, mounted, readonly;
  logic [2:0] fileno;
  logic [1:0] filetype;
  logic [31:0] filesize;
  logic [7:0] ram_q;
  state_t state, state_n;
  logic [NDRV-1:0] rd_n, wr_n, onehot;
  logic done_n, lba_sel, wr_evt, ram_we, rd_fall, rd_rise, wr_rise, valid, ack_fall, mnt_rise;
  logic [2:0] drv;
  logic unused;
  assign unused = ^{zpu_out2[31:6], zpu_wr[15:7], zpu_wr[4:0], zpu_rd[15:3], zpu_rd[1:0], img_size[63:32]};
  assign lba_sel = zpu_out2[LBA_SEL];
  assign drv = zpu_out2[DRV_MSB:DRV_LSB];
  assign wr_evt = dwr_q[1] & ~dwr_q[2];
  assign ram_we = wr_evt & ~lba_sel;
  assign rd_fall = rd_q & ~zpu_rd[DATA_RD];
  assign rd_rise = zpu_out2[BLK_RD] & ~blk_q[0];
  assign wr_rise = zpu_out2[BLK_WR] & ~blk_q[1];
  assign valid = (drv == 3'd0) || (drv == 3'd1) || (drv == 3'd4);
  assign onehot = NDRV'(1) << {drv[2], drv[0]};
  assign ack_fall = ack_q & ~sd_ack;
  assign mnt_rise = (|img_mounted) & ~mnt_q;
  assign zpu_in2 = {readonly, filetype, fileno, mounted, io_done};
  assign zpu_in3 = lba_sel ? filesize : {24'b0, ram_q};
  zpu_sd_bridge_dpram #(.AW(SECT_AW), .DW(8)) u_buf (
    .clk(clk_sys),
    .addr_a(ptr), .din_a(zpu_out3[7:0]), .wr_a(ram_we), .dout_a(ram_q),
    .addr_b(sd_buff_addr), .din_b(sd_buff_dout), .wr_b(sd_buff_wr), .dout_b(sd_buff_din)
  );
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dwr_q <= '0;
      blk_q <= '0;
      rd_q <= 1'b0;
      ack_q <= 1'b0;
      mnt_q <= 1'b0;
      inc_q <= 1'b0;
      ptr <= '0;
      sd_lba <= '0;
      mounted <= 1'b0;
      readonly <= 1'b0;
      fileno <= '0;
      filetype <= '0;
      filesize <= '0;
    end else begin
      dwr_q <= {dwr_q[1:0], zpu_wr[DATA_WR]};
      blk_q <= {zpu_out2[BLK_WR], zpu_out2[BLK_RD]};
      rd_q <= zpu_rd[DATA_RD];
      ack_q <= sd_ack;
      mnt_q <= |img_mounted;
      inc_q <= ram_we;
      if (wr_evt & lba_sel) sd_lba <= zpu_out3;
      // pointer clear outranks any pending increment
      if (zpu_wr[IO_WR]) ptr <= '0;
      else if (inc_q | rd_fall) ptr <= ptr + 1'b1;
      if (mnt_rise) begin
        fileno <= img_mounted[2] ? FILENO2 : img_mounted[1] ? FILENO1 : FILENO0;
        filetype <= img_filetype;
        readonly <= img_readonly | img_mounted[2];
        filesize <= img_size[31:0];
        mounted <= ~mounted;
      end
    end
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sd_rd <= '0;
      sd_wr <= '0;
      io_done <= 1'b0;
    end else begin
      state <= state_n;
      sd_rd <= rd_n;
      sd_wr <= wr_n;
      io_done <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if ((rd_rise | wr_rise) & valid) state_n = REQ;
      REQ: if (sd_ack) state_n = XFER;
      XFER: if (ack_fall) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // read wins over a simultaneous write edge; invalid slots just report done
  always_comb begin
    rd_n = sd_rd;
    wr_n = sd_wr;
    done_n = io_done;
    case (state)
      IDLE: if (rd_rise | wr_rise) begin
        rd_n = (valid & rd_rise) ? onehot : '0;
        wr_n = (valid & ~rd_rise) ? onehot : '0;
        done_n = ~valid;
      end
      REQ: if (sd_ack) begin
        rd_n = '0;
        wr_n = '0;
      end
      XFER: if (ack_fall) done_n = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_zpu_sd_bridge.sv
// tb_zpu_sd_bridge: randomized transaction-level checks against a sector/pointer/mount model
module tb_zpu_sd_bridge;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic [31:0] zpu_out2 = '0, zpu_out3 = '0;
  logic [15:0] zpu_wr = '0, zpu_rd = '0;
  logic [7:0] zpu_in2;
  logic [31:0] zpu_in3, sd_lba;
  logic [2:0] sd_rd, sd_wr, img_mounted = '0;
  logic sd_ack = 1'b0, sd_buff_wr = 1'b0, img_readonly = 1'b0;
  logic [8:0] sd_buff_addr = '0;
  logic [7:0] sd_buff_dout = '0, sd_buff_din;
  logic [63:0] img_size = '0;
  logic [1:0] img_filetype = '0;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mem [512];
  int ptr = 0;
  logic [31:0] m_lba = '0;
  bit m_tog = 0;

  zpu_sd_bridge dut (
    .clk_sys(clk_sys), .reset(reset), .zpu_out2(zpu_out2), .zpu_out3(zpu_out3),
    .zpu_wr(zpu_wr), .zpu_rd(zpu_rd), .zpu_in2(zpu_in2), .zpu_in3(zpu_in3),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
    .sd_buff_wr(sd_buff_wr), .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_size(img_size), .img_filetype(img_filetype)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [2:0] slot_mask(logic [2:0] drv);
    case (drv)
      3'd0: return 3'b001;
      3'd1: return 3'b010;
      3'd4: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic zclr();
    zpu_wr[5] = 1'b1;
    tick(1);
    zpu_wr[5] = 1'b0;
    tick(1);
    ptr = 0;
  endtask

  task automatic zwrite(bit lba, logic [31:0] v);
    zpu_out2 = {31'b0, lba};
    zpu_out3 = v;
    zpu_wr[6] = 1'b1;
    tick(2);
    zpu_wr[6] = 1'b0;
    tick(6);
    zpu_out2 = '0;
    if (lba) m_lba = v;
    else begin
      mem[ptr] = v[7:0];
      ptr = (ptr + 1) % 512;
    end
  endtask

  task automatic zread(string tag);
    zpu_out2 = '0;
    tick(2);
    check(tag, zpu_in3, {24'b0, mem[ptr]});
    zpu_rd[2] = 1'b1;
    tick(1);
    zpu_rd[2] = 1'b0;
    tick(1);
    ptr = (ptr + 1) % 512;
  endtask

  task automatic hwrite(logic [8:0] a, logic [7:0] d);
    sd_buff_addr = a;
    sd_buff_dout = d;
    sd_buff_wr = 1'b1;
    tick(1);
    sd_buff_wr = 1'b0;
    mem[a] = d;
  endtask

  task automatic hread(logic [8:0] a);
    sd_buff_addr = a;
    tick(2);
    check("hps_rd", sd_buff_din, mem[a]);
  endtask

  task automatic blk(bit r, bit w, logic [2:0] drv, int ack_len);
    logic [2:0] m;
    int k;
    m = slot_mask(drv);
    zpu_out2 = {26'b0, drv, w, r, 1'b0};
    tick(1);
    zpu_out2[2:1] = 2'b00;
    tick(1);
    if (m == 3'b000) begin
      check("inv_rd", sd_rd, 0);
      check("inv_wr", sd_wr, 0);
      check("inv_done", zpu_in2[0], 1);
    end else begin
      check("req_rd", sd_rd, r ? m : 3'b000);
      check("req_wr", sd_wr, r ? 3'b000 : m);
      check("req_done", zpu_in2[0], 0);
      zpu_out2[1] = 1'b1;
      tick(2);
      zpu_out2[1] = 1'b0;
      tick(1);
      check("req_hold_rd", sd_rd, r ? m : 3'b000);
      sd_ack = 1'b1;
      tick(ack_len);
      check("ack_rd", sd_rd, 0);
      check("ack_wr", sd_wr, 0);
      zpu_out2[1] = 1'b1;
      zpu_out2[2] = 1'b1;
      tick(1);
      zpu_out2[2:1] = 2'b00;
      tick(1);
      check("xfer_ign_rd", sd_rd, 0);
      check("xfer_ign_wr", sd_wr, 0);
      check("xfer_done", zpu_in2[0], 0);
      sd_ack = 1'b0;
      k = 0;
      while (!zpu_in2[0] && k < 10) begin
        tick(1);
        k++;
      end
      check("done_lat", k, 1);
      check("done", zpu_in2[0], 1);
    end
    zpu_out2 = '0;
    tick(1);
  endtask

  task automatic mount(logic [2:0] m, bit ro, logic [1:0] ft, logic [63:0] sz);
    logic [2:0] fn;
    fn = m[2] ? 3'd4 : (m[1] ? 3'd1 : 3'd0);
    img_readonly = ro;
    img_filetype = ft;
    img_size = sz;
    img_mounted = m;
    tick(1);
    img_mounted = '0;
    tick(1);
    m_tog = ~m_tog;
    check("mount_st", zpu_in2[7:1], {ro | m[2], ft, fn, m_tog});
    zpu_out2 = 32'd1;
    tick(1);
    check("mount_size", zpu_in3, sz[31:0]);
    zpu_out2 = '0;
    tick(1);
  endtask

  initial begin
    tick(3);
    check("rst_in2", zpu_in2, 0);
    check("rst_rd", sd_rd, 0);
    check("rst_wr", sd_wr, 0);
    check("rst_lba", sd_lba, 0);
    reset = 1'b0;
    tick(2);
    zpu_out2 = 32'd1;
    tick(1);
    check("rst_size", zpu_in3, 0);
    zpu_out2 = '0;
    // directed scenarios
    zclr();
    zwrite(0, 32'hA5);
    zwrite(0, 32'h5A);
    zclr();
    zread("rd_a5");
    zread("rd_5a");
    zwrite(1, 32'h0000_1234);
    check("lba", sd_lba, m_lba);
    blk(1, 0, 3'd4, 3);
    blk(1, 1, 3'd1, 1);
    blk(0, 1, 3'd2, 1);
    mount(3'b100, 1'b0, 2'd2, 64'h1_0000_2000);
    // fill and wrap the whole buffer
    zclr();
    for (int i = 0; i < 513; i++) zwrite(0, $urandom);
    check("wrap_ptr_model", ptr, 1);
    zclr();
    zread("wrap0");
    zread("wrap1");
    // randomized mixed traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 6))
        0: zwrite(0, $urandom);
        1: zread("rnd_rd");
        2: hwrite(9'($urandom), 8'($urandom));
        3: hread(9'($urandom));
        4: begin
          zwrite(1, $urandom);
          check("rnd_lba", sd_lba, m_lba);
        end
        5: begin
          logic [1:0] rw;
          rw = 2'($urandom_range(1, 3));
          blk(rw[0], rw[1], 3'($urandom), $urandom_range(1, 3));
        end
        default: mount(3'($urandom_range(1, 7)), 1'($urandom), 2'($urandom), {$urandom, $urandom});
      endcase
      if ($urandom_range(0, 7) == 0) zclr();
    end
    // asynchronous reset during REQ
    zpu_out2 = {26'b0, 3'd0, 2'b01, 1'b0};
    tick(1);
    zpu_out2 = '0;
    tick(1);
    check("pre_rst_rd", sd_rd, 3'b001);
    #3 reset = 1'b1;
    #1;
    check("arst_rd", sd_rd, 0);
    check("arst_in2", zpu_in2, 0);
    check("arst_lba", sd_lba, 0);
    zpu_out2 = 32'd1;
    #1;
    check("arst_size", zpu_in3, 0);
    zpu_out2 = '0;
    tick(2);
    reset = 1'b0;
    ptr = 0;
    m_tog = 0;
    m_lba = '0;
    tick(1);
    zread("post_rst_rd");
    blk(1, 0, 3'd0, 2);
    mount(3'b001, 1'b0, 2'd1, 64'h55);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
